// File: rtl/cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// cnt_seq_checker
//
// Purpose: watches samples of an upstream free-running 8-bit counter. It locks
//          after LOCK_N consecutive +1 increments. Once locked, it flags every
//          sample that is not prev+1 (mod 256) with a one-cycle pulse and keeps
//          a saturating error count.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   din[7:0]   in   counter sample
//   din_vld    in   din is valid this cycle
//   clr        in   synchronous clear of err_cnt; wins over a same-cycle error
//   locked     out  high while in LOCKED
//   err_pulse  out  one-cycle pulse per sequence error seen while locked
//   err_cnt    out  saturating (255) error count
//   last_data  out  most recent accepted din
//
// Parameter:
//   LOCK_N     consecutive good increments needed to lock (1..15)
//
// Optional feature: define CNT_SEQ_CHECKER_RELOCK_EN to drop from LOCKED back
// to HUNT after 4 consecutive errors. Without it, LOCKED is held until rst.
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | no prior sample held since reset
// HUNT   | prior sample held, counting a run of good increments
// LOCKED | run reached LOCK_N, mismatches are reported as errors
// -----------------------------------------------------------------------------
module cnt_seq_checker #(
    parameter int LOCK_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    input  logic       clr,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [7:0] last_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

    state_t     state, state_nx;
    logic [3:0] run, run_nx;
    logic [3:0] run_inc;
    logic [7:0] prev, prev_nx;
    logic [7:0] prev_inc;
    logic [7:0] last_nx;
    logic [7:0] err_cnt_nx;
    logic       err_pulse_nx;
    logic       match;

`ifdef CNT_SEQ_CHECKER_RELOCK_EN
    logic [2:0] bad_run, bad_run_nx;
`endif

    // 8-bit add wraps, so 0xFF -> 0x00 counts as a match
    assign prev_inc = prev + 8'd1;
    assign match    = (din == prev_inc);
    assign run_inc  = run + 4'd1;

    always_comb begin
        state_nx     = state;
        run_nx       = run;
        prev_nx      = prev;
        last_nx      = last_data;
        err_cnt_nx   = err_cnt;
        err_pulse_nx = 1'b0;
`ifdef CNT_SEQ_CHECKER_RELOCK_EN
        bad_run_nx   = bad_run;
`endif

        if (din_vld) begin
            prev_nx = din;
            last_nx = din;
            case (state)
                IDLE: begin
                    state_nx = HUNT;
                    run_nx   = 4'd0;
                end
                HUNT: begin
                    if (match) begin
                        run_nx = run_inc;
                        if (run_inc == LOCK_RUN) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        run_nx = 4'd0;
                    end
                end
                LOCKED: begin
                    if (match) begin
`ifdef CNT_SEQ_CHECKER_RELOCK_EN
                        bad_run_nx = 3'd0;
`endif
                    end else begin
                        err_pulse_nx = 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt_nx = err_cnt + 8'd1;
                        end
`ifdef CNT_SEQ_CHECKER_RELOCK_EN
                        // fourth consecutive error: give up the lock and re-hunt
                        if (bad_run == 3'd3) begin
                            state_nx   = HUNT;
                            run_nx     = 4'd0;
                            bad_run_nx = 3'd0;
                        end else begin
                            bad_run_nx = bad_run + 3'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_nx = IDLE;
                    run_nx   = 4'd0;
                end
            endcase
        end

        // clr wins over a coincident increment; the pulse above is unaffected
        if (clr) begin
            err_cnt_nx = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            run       <= 4'd0;
            prev      <= 8'd0;
            last_data <= 8'd0;
            err_cnt   <= 8'd0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
`ifdef CNT_SEQ_CHECKER_RELOCK_EN
            bad_run   <= 3'd0;
`endif
        end else begin
            state     <= state_nx;
            run       <= run_nx;
            prev      <= prev_nx;
            last_data <= last_nx;
            err_cnt   <= err_cnt_nx;
            err_pulse <= err_pulse_nx;
            locked    <= (state_nx == LOCKED);
`ifdef CNT_SEQ_CHECKER_RELOCK_EN
            bad_run   <= bad_run_nx;
`endif
        end
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq_checker
//
// Purpose: self-checking bench for cnt_seq_checker (LOCK_N = 4). A driver
//          applies directed vectors on the falling edge and queues the output
//          expected after the next rising edge. A monitor pops one entry per
//          cycle, just after the rising edge, and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_cnt_seq_checker;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_vld;
    logic       clr;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] last_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       locked;
        logic       err_pulse;
        logic [7:0] err_cnt;
        logic [7:0] last_data;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    cnt_seq_checker #(.LOCK_N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .last_data (last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: one expected entry per driven cycle, checked 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            checks++;
            if (locked !== e_mon.locked || err_pulse !== e_mon.err_pulse ||
                err_cnt !== e_mon.err_cnt || last_data !== e_mon.last_data) begin
                errors++;
                $display("FAIL %s: got locked=%b pulse=%b cnt=%h last=%h, want locked=%b pulse=%b cnt=%h last=%h",
                         e_mon.name, locked, err_pulse, err_cnt, last_data,
                         e_mon.locked, e_mon.err_pulse, e_mon.err_cnt, e_mon.last_data);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic c, input logic [7:0] d,
                         input logic el, input logic ep, input logic [7:0] ec,
                         input logic [7:0] ed, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        din_vld = v;
        clr     = c;
        din     = d;
        e.locked    = el;
        e.err_pulse = ep;
        e.err_cnt   = ec;
        e.last_data = ed;
        e.name      = nm;
        sb.push_back(e);
    endtask

    // plain valid sample: no rst, no clr
    task automatic smp(input logic [7:0] d, input logic el, input logic ep,
                       input logic [7:0] ec, input string nm);
        drive(1'b0, 1'b1, 1'b0, d, el, ep, ec, d, nm);
    endtask

    initial begin
        logic [7:0] p;
        logic [7:0] ec;
        rst = 1'b1; din_vld = 1'b0; clr = 1'b0; din = 8'h00;

        // reset, with a coincident valid sample that must be discarded
        drive(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, "reset_discard");
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, "reset_state");

        // lock on 0x10..0x14
        smp(8'h10, 1'b0, 1'b0, 8'h00, "idle_to_hunt");
        smp(8'h11, 1'b0, 1'b0, 8'h00, "hunt_run1");
        smp(8'h12, 1'b0, 1'b0, 8'h00, "hunt_run2");
        smp(8'h13, 1'b0, 1'b0, 8'h00, "hunt_run3");
        smp(8'h14, 1'b1, 1'b0, 8'h00, "lock_at_0x14");

        // invalid cycle must be ignored entirely
        drive(1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 8'h00, 8'h14, "vld_low_ignored");

        for (int v = 8'h15; v <= 8'h20; v++) smp(8'(v), 1'b1, 1'b0, 8'h00, "locked_stream");

        // single error: 0x40 after 0x20, then 0x41 is good again
        smp(8'h40, 1'b1, 1'b1, 8'h01, "err_0x40");
        smp(8'h41, 1'b1, 1'b0, 8'h01, "after_err_match");

        // run through the 0xFF -> 0x00 wrap
        for (int v = 8'h42; v <= 9'h101; v++) smp(8'(v), 1'b1, 1'b0, 8'h01, "wrap_stream");

        // six errors, each followed by a resync match, bringing err_cnt to 7
        p = 8'h01;
        for (int k = 0; k < 6; k++) begin
            ec = 8'(k + 2);
            smp(p + 8'd2, 1'b1, 1'b1, ec, "err_build");
            smp(p + 8'd3, 1'b1, 1'b0, ec, "err_build_resync");
            p = p + 8'd3;
        end

        // clr coincident with an error: count clears, pulse still fires
        drive(1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 1'b1, 8'h00, 8'h20, "clr_with_err");
        smp(8'h21, 1'b1, 1'b0, 8'h00, "after_clr_match");
        smp(8'h30, 1'b1, 1'b1, 8'h01, "err_after_clr");
        drive(1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 8'h30, "clr_only_keeps_lock");

        // reset mid-lock: everything back to reset values, full relock needed
        drive(1'b1, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 8'h00, 8'h00, "rst_mid_lock");
        smp(8'h31, 1'b0, 1'b0, 8'h00, "post_rst_idle");
        smp(8'h32, 1'b0, 1'b0, 8'h00, "post_rst_run1");
        smp(8'h50, 1'b0, 1'b0, 8'h00, "hunt_mismatch_quiet");
        smp(8'h51, 1'b0, 1'b0, 8'h00, "rehunt_run1");
        smp(8'h52, 1'b0, 1'b0, 8'h00, "rehunt_run2");
        smp(8'h53, 1'b0, 1'b0, 8'h00, "rehunt_run3");
        smp(8'h54, 1'b1, 1'b0, 8'h00, "relock_0x54");

`ifdef CNT_SEQ_CHECKER_RELOCK_EN
        // four consecutive errors drop the lock; four good increments restore it
        smp(8'h56, 1'b1, 1'b1, 8'h01, "relock_err1");
        smp(8'h58, 1'b1, 1'b1, 8'h02, "relock_err2");
        smp(8'h5A, 1'b1, 1'b1, 8'h03, "relock_err3");
        smp(8'h5C, 1'b0, 1'b1, 8'h04, "relock_err4_unlock");
        smp(8'h5D, 1'b0, 1'b0, 8'h04, "relock_good1");
        smp(8'h5E, 1'b0, 1'b0, 8'h04, "relock_good2");
        smp(8'h5F, 1'b0, 1'b0, 8'h04, "relock_good3");
        smp(8'h60, 1'b1, 1'b0, 8'h04, "relock_good4");
`else
        // 300 consecutive errors: count saturates at 0xFF, lock held
        p = 8'h54;
        for (int k = 0; k < 300; k++) begin
            p  = p + 8'd2;
            ec = (k + 1 > 255) ? 8'hFF : 8'(k + 1);
            smp(p, 1'b1, 1'b1, ec, "saturate");
        end
`endif

        drive(1'b0, 1'b0, 1'b0, 8'h00, locked_final(), 1'b0, final_cnt(), final_last(), "idle_tail");

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // expected outputs after the final invalid cycle (hand-derived per build)
    function automatic logic locked_final();
        return 1'b1;
    endfunction

    function automatic logic [7:0] final_cnt();
`ifdef CNT_SEQ_CHECKER_RELOCK_EN
        return 8'h04;
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic [7:0] final_last();
`ifdef CNT_SEQ_CHECKER_RELOCK_EN
        return 8'h60;
`else
        // 0x54 + 2*300 = 0x54 + 0x258 -> low byte 0xAC
        return 8'hAC;
`endif
    endfunction

endmodule
